// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use master.
interface mem_arbiter_if #(
  parameter int W = 32
);
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_ready;
  logic [W-1:0] if_rdata;

  logic         dm_req;
  logic         dm_we;
  logic [W-1:0] dm_addr;
  logic [W-1:0] dm_wdata;
  logic         dm_ready;
  logic [W-1:0] dm_rdata;

  logic         mem_en;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ack;

  logic         stall;
  logic         err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between instruction fetch and data ports.
// Define ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT cycles without mem_ack.
module mem_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e       state_q, state_d;
  logic         owner_q, owner_d;      // 1 = data port owns the transaction
  logic         last_dm_q, last_dm_d;
  logic         we_q, we_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] if_rdata_q, if_rdata_d;
  logic [W-1:0] dm_rdata_q, dm_rdata_d;
  logic         timeoutHit;
  logic         grantDm;
  logic [W-1:0] respData;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // Counter is held at zero outside BUSY, so it starts fresh on every BUSY entry
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) cnt_d = cnt_q + CW'(1);
  end

  assign timeoutHit = (state_q == BUSY) && !bus_io.mem_ack && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeoutHit;
    end
  end

  assign bus_io.err = err_q;
`else
  assign timeoutHit = 1'b0;
  assign bus_io.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_dm_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_dm_q  <= last_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_dm_d  = last_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grantDm    = 1'b0;
    respData   = bus_io.mem_ack ? bus_io.mem_rdata : '0;

    case (state_q)
      IDLE: begin
        if (bus_io.if_req || bus_io.dm_req) begin
          // On contention the port that lost last time wins
          grantDm   = bus_io.dm_req && (!bus_io.if_req || !last_dm_q);
          owner_d   = grantDm;
          last_dm_d = grantDm;
          we_d      = grantDm && bus_io.dm_we;
          addr_d    = grantDm ? bus_io.dm_addr : bus_io.if_addr;
          wdata_d   = grantDm ? bus_io.dm_wdata : '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus_io.mem_ack || timeoutHit) begin
          state_d = RESP;
          if (!owner_q)    if_rdata_d = respData;
          else if (!we_q)  dm_rdata_d = respData;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.mem_en    = (state_q == BUSY);
  assign bus_io.mem_we    = (state_q == BUSY) && we_q;
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.mem_wdata = wdata_q;
  assign bus_io.if_ready  = (state_q == RESP) && !owner_q;
  assign bus_io.dm_ready  = (state_q == RESP) && owner_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.dm_rdata  = dm_rdata_q;
  assign bus_io.stall     = (bus_io.if_req || bus_io.dm_req) && !(bus_io.if_ready || bus_io.dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-schedule model.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int TO = 16;
  localparam int RANDOM_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.W(W)) bus ();
  mem_arbiter #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Waits for the next rising edge, drives all inputs, then lets outputs settle
  task automatic applyStimulus(input logic ir, input logic [W-1:0] ia,
                               input logic dr, input logic dwe,
                               input logic [W-1:0] da, input logic [W-1:0] dwd,
                               input logic ack, input logic [W-1:0] rd);
    @(posedge clk);
    #1;
    bus.if_req = ir;  bus.if_addr = ia;
    bus.dm_req = dr;  bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
    bus.mem_ack = ack; bus.mem_rdata = rd;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h55; bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 32'h66; bus.dm_wdata = 32'h77; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h88;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst if_ready", bus.if_ready, 0);
    checkOutput("rst dm_ready", bus.dm_ready, 0);
    checkOutput("rst mem_en", bus.mem_en, 0);
    checkOutput("rst mem_we", bus.mem_we, 0);
    checkOutput("rst err", bus.err, 0);
    checkOutput("rst if_rdata", bus.if_rdata, 0);
    checkOutput("rst dm_rdata", bus.dm_rdata, 0);
    checkOutput("rst mem_addr", bus.mem_addr, 0);
    checkOutput("rst mem_wdata", bus.mem_wdata, 0);
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single fetch with mem_ack on the first BUSY cycle
  task automatic fetchOnce(input logic [W-1:0] addr, input logic [W-1:0] data);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("fetch c0 mem_en", bus.mem_en, 0);
    checkOutput("fetch c0 stall", bus.stall, 1);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, '0, 1'b1, data);
    checkOutput("fetch c1 mem_en", bus.mem_en, 1);
    checkOutput("fetch c1 mem_addr", bus.mem_addr, addr);
    checkOutput("fetch c1 mem_we", bus.mem_we, 0);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("fetch c2 if_ready", bus.if_ready, 1);
    checkOutput("fetch c2 dm_ready", bus.dm_ready, 0);
    checkOutput("fetch c2 if_rdata", bus.if_rdata, data);
    checkOutput("fetch c2 stall", bus.stall, 0);
    checkOutput("fetch c2 mem_en", bus.mem_en, 0);
    idleCycle();
    checkOutput("fetch c3 if_ready", bus.if_ready, 0);
  endtask

  // Random-phase model state: one transaction tracked as a cycle schedule
  logic         ifPend, dmPend, dmWe, ifDone, dmDone;
  logic [W-1:0] ifA, dmA, dmWd;
  logic         active, ownerDm, lastDm, expWe, grantDm;
  logic [W-1:0] expAddr, expWd, expIfRdata, expDmRdata;
  int           busyFrom, ackCycle;
  logic         inBusy, ackNow, expReady, ackDrv;
  logic [W-1:0] rdDrv;

  initial begin
    doReset();

    // Fetch 0x100, instruction 0x00500093
    fetchOnce(32'h100, 32'h0050_0093);

    // Write with three wait cycles: memory sees the write for four cycles
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b0, '0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, (i == 4), 32'h1234_5678);
      checkOutput("wr mem_en", bus.mem_en, 1);
      checkOutput("wr mem_we", bus.mem_we, 1);
      checkOutput("wr mem_addr", bus.mem_addr, 32'h2000);
      checkOutput("wr mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      checkOutput("wr dm_ready early", bus.dm_ready, 0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b0, '0);
    checkOutput("wr dm_ready", bus.dm_ready, 1);
    checkOutput("wr if_ready", bus.if_ready, 0);
    checkOutput("wr dm_rdata kept", bus.dm_rdata, 0);
    idleCycle();
    checkOutput("wr dm_ready drop", bus.dm_ready, 0);

    // Simultaneous requests after reset: data first, then fetch
    doReset();
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, '0, 1'b1, 32'h1111);
    checkOutput("rr first addr", bus.mem_addr, 32'h300);
    checkOutput("rr first stall", bus.stall, 1);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0);
    checkOutput("rr dm_ready", bus.dm_ready, 1);
    checkOutput("rr if_ready early", bus.if_ready, 0);
    checkOutput("rr dm_rdata", bus.dm_rdata, 32'h1111);
    checkOutput("rr stall in ready", bus.stall, 0);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0);
    checkOutput("rr idle mem_en", bus.mem_en, 0);
    checkOutput("rr idle stall", bus.stall, 1);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, '0, 1'b1, 32'h2222);
    checkOutput("rr second addr", bus.mem_addr, 32'h40);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0);
    checkOutput("rr if_ready", bus.if_ready, 1);
    checkOutput("rr if_rdata", bus.if_rdata, 32'h2222);
    checkOutput("rr stall in ready 2", bus.stall, 0);

    // mem_ack while idle must be ignored
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFF);
    idleCycle();
    checkOutput("spur if_ready", bus.if_ready, 0);
    checkOutput("spur dm_ready", bus.dm_ready, 0);
    checkOutput("spur mem_en", bus.mem_en, 0);
    checkOutput("spur if_rdata", bus.if_rdata, 32'h2222);
    checkOutput("spur dm_rdata", bus.dm_rdata, 32'h1111);
    idleCycle();
    checkOutput("spur mem_en later", bus.mem_en, 0);

    // Reset in the middle of BUSY aborts without a ready pulse
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("abort busy mem_en", bus.mem_en, 1);
    #1;
    rst = 1'b1;
    bus.if_req = 1'b0;
    #1;
    checkOutput("abort async mem_en", bus.mem_en, 0);
    checkOutput("abort if_ready", bus.if_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("abort no ready", bus.if_ready, 0);
      checkOutput("abort no mem_en", bus.mem_en, 0);
    end
    fetchOnce(32'h44, 32'hA5A5_A5A5);

    // Memory that never acknowledges
    doReset();
    fetchOnce(32'h10, 32'h1234);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, 1'b0, '0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      checkOutput("to busy mem_en", bus.mem_en, 1);
      checkOutput("to busy err", bus.err, 0);
      checkOutput("to busy if_ready", bus.if_ready, 0);
    end
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("to if_ready", bus.if_ready, 1);
    checkOutput("to err", bus.err, 1);
    checkOutput("to if_rdata", bus.if_rdata, 0);
    idleCycle();
    checkOutput("to err drop", bus.err, 0);
`else
    for (int i = 1; i <= TO + 4; i++) begin
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      checkOutput("noto mem_en", bus.mem_en, 1);
      checkOutput("noto err", bus.err, 0);
      checkOutput("noto if_ready", bus.if_ready, 0);
    end
`endif

    // Randomized traffic against the schedule model
    doReset();
    {ifPend, dmPend, dmWe, ifDone, dmDone, active, ownerDm, lastDm, expWe} = '0;
    {ifA, dmA, dmWd, expAddr, expWd, expIfRdata, expDmRdata} = '0;
    busyFrom = 0;
    ackCycle = 0;
    for (int cyc = 0; cyc < RANDOM_CYCLES; cyc++) begin
      if (ifDone) begin ifPend = 1'b0; ifDone = 1'b0; end
      if (dmDone) begin dmPend = 1'b0; dmDone = 1'b0; end
      if (!ifPend && $urandom_range(0, 2) == 0) begin
        ifPend = 1'b1; ifA = $urandom;
      end
      if (!dmPend && $urandom_range(0, 2) == 0) begin
        dmPend = 1'b1; dmWe = 1'($urandom_range(0, 1)); dmA = $urandom; dmWd = $urandom;
      end
      inBusy = active && (cyc >= busyFrom) && (cyc <= ackCycle);
      ackNow = inBusy && (cyc == ackCycle);
      rdDrv  = $urandom;
      ackDrv = ackNow || (!inBusy && $urandom_range(0, 3) == 0);
      applyStimulus(ifPend, ifA, dmPend, dmWe, dmA, dmWd, ackDrv, rdDrv);

      expReady = active && (cyc == ackCycle + 1);
      checkOutput("rnd mem_en", bus.mem_en, inBusy);
      if (inBusy) begin
        checkOutput("rnd mem_we", bus.mem_we, expWe);
        checkOutput("rnd mem_addr", bus.mem_addr, expAddr);
        checkOutput("rnd mem_wdata", bus.mem_wdata, expWd);
      end
      checkOutput("rnd if_ready", bus.if_ready, expReady && !ownerDm);
      checkOutput("rnd dm_ready", bus.dm_ready, expReady && ownerDm);
      checkOutput("rnd if_rdata", bus.if_rdata, expIfRdata);
      checkOutput("rnd dm_rdata", bus.dm_rdata, expDmRdata);
      checkOutput("rnd stall", bus.stall, (ifPend || dmPend) && !expReady);
      checkOutput("rnd err", bus.err, 0);

      if (ackNow) begin
        if (!ownerDm)    expIfRdata = rdDrv;
        else if (!expWe) expDmRdata = rdDrv;
      end
      if (!active) begin
        if (ifPend || dmPend) begin
          grantDm  = dmPend && (!ifPend || !lastDm);
          ownerDm  = grantDm;
          lastDm   = grantDm;
          expAddr  = grantDm ? dmA : ifA;
          expWe    = grantDm && dmWe;
          expWd    = grantDm ? dmWd : '0;
          active   = 1'b1;
          busyFrom = cyc + 1;
          ackCycle = busyFrom + int'($urandom_range(0, 4));
        end
      end else if (cyc == ackCycle + 1) begin
        active = 1'b0;
        if (ownerDm) dmDone = 1'b1;
        else         ifDone = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter W, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum wait cycles for mem_ack (used only under REQ-026).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port if_req, input, 1, instruction-fetch request, held until if_ready.
REQ-006 SHALL have port if_addr, input, W, fetch address.
REQ-007 SHALL have ports if_ready (output, 1, fetch-complete pulse) and if_rdata (output, W, fetched instruction).
REQ-008 SHALL have ports dm_req (input, 1), dm_we (input, 1), dm_addr (input, W) and dm_wdata (input, W) for data-memory requests.
REQ-009 SHALL have ports dm_ready (output, 1, data-complete pulse) and dm_rdata (output, W, load data).
REQ-010 SHALL have ports mem_en, mem_we (outputs, 1) and mem_addr, mem_wdata (outputs, W) to the shared memory.
REQ-011 SHALL have ports mem_rdata (input, W) and mem_ack (input, 1, memory-done strobe).
REQ-012 SHALL have ports stall (output, 1, high while any request is pending and not yet acknowledged) and err (output, 1, timeout pulse).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 In IDLE: no request -> stay IDLE; one request -> latch that port's addr/we/wdata, record owner, go BUSY.
REQ-015 Both requests in IDLE: grant the port not granted last (round-robin via last_grant register).
REQ-016 In BUSY: mem_en=1, mem_addr/mem_we/mem_wdata driven from latched values; mem_we=0 when owner is fetch.
REQ-017 In BUSY with mem_ack sampled high: register mem_rdata into owner's rdata register, go RESP.
REQ-018 In RESP: owner's ready=1 for exactly one cycle, mem_en=0, then IDLE unconditionally.
REQ-019 Requests are sampled only in IDLE; a req held high into the IDLE following RESP is a new request.
REQ-020 Minimum latency: req at cycle 0 -> mem_en cycle 1 -> ack cycle 1 -> ready cycle 2 -> IDLE cycle 3.
REQ-021 if_rdata/dm_rdata hold their last value until the next completion on the same port; write completions leave dm_rdata unchanged.
REQ-022 mem_ack outside BUSY SHALL be ignored.
REQ-023 stall = (if_req or dm_req) and not (if_ready or dm_ready).

Reset
REQ-024 rst high SHALL immediately force state=IDLE, last_grant=fetch, latched addr/wdata/we=0, counter=0.
REQ-025 During and after reset: if_ready=dm_ready=mem_en=mem_we=err=0, if_rdata=dm_rdata=mem_addr=mem_wdata=0; reset mid-BUSY aborts the transaction with no ready pulse.

Configuration
REQ-026 With macro ARB_TIMEOUT_EN defined: cycle counter clears on BUSY entry and increments each BUSY cycle; after TIMEOUT cycles without mem_ack, go RESP, pulse owner ready and err together, owner rdata=0.
REQ-027 Without ARB_TIMEOUT_EN: no counter; BUSY waits indefinitely; err tied 0.

Verification
REQ-028 if_req=1, if_addr=0x100, mem_ack on first BUSY cycle with mem_rdata=0x00500093 -> mem_addr=0x100 cycle 1, if_ready cycle 2, if_rdata=0x00500093.
REQ-029 dm_req=1, dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF, ack after 3 wait cycles -> mem_we=1 with those values for 4 cycles, dm_ready one cycle, dm_rdata unchanged.
REQ-030 if_req and dm_req together after reset, both held through two transactions -> dm granted first, fetch second; stall low only during each ready cycle.
REQ-031 rst asserted mid-BUSY -> mem_en drops asynchronously, no ready pulse, next request serviced normally.
REQ-032 ARB_TIMEOUT_EN defined, TIMEOUT=16, mem_ack never asserted -> after 16 BUSY cycles if_ready=err=1 one cycle, if_rdata=0; without macro FSM remains BUSY.
REQ-033 mem_ack pulsed while IDLE with no requests -> no ready, no state change.
